tohost_monitor: RTL and testbench

- Sits directly downstream of the CSR write stage and consumes its registered `tohost_csr` word.
- Decodes the riscv-tests tohost convention into sticky pass/fail/timeout status and a cycle count.
- Buffers console-character writes in a small FIFO with a valid/ready drain port.
- Used by the testbench and by the FPGA status/UART logic.

---
 rtl/tohost_pkg.sv | 15 +
 rtl/tohost_char_fifo.sv | 48 ++++
 rtl/tohost_monitor.sv | 100 ++++++++++
 tb/tb_tohost_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost monitor: run-state encoding,
// the riscv-tests pass word and the default console-character tag.
package tohost_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } tohost_state_t;

    localparam logic [31:0] TOHOST_PASS      = 32'h0000_0001;
    localparam logic [15:0] CHAR_TAG_DEFAULT = 16'h0101;

endpackage

// File: rtl/tohost_char_fifo.sv
// Synchronous FIFO for console characters. Extra pointer MSB distinguishes
// full from empty; head reads as zero while the FIFO is empty.
module tohost_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tohost_monitor.sv
// Decodes the riscv-tests tohost word into sticky pass/fail/timeout status,
// counts run cycles, and queues console characters for a valid/ready consumer.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter int          CHAR_DEPTH     = 8,
    parameter logic [15:0] CHAR_TAG       = CHAR_TAG_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   tohost_csr,
    output logic          done,
    output logic          pass,
    output logic          fail,
    output logic [30:0]   fail_code,
    output logic          timeout,
    output logic [31:0]   cycles,
    output logic          char_valid,
    output logic [7:0]    char_data,
    input  logic          char_ready,
    output logic          char_overflow,
    output tohost_state_t state_dbg
);

    tohost_state_t state;
    tohost_state_t state_nx;
    logic [31:0]   prev;
    logic          ev;
    logic          running;
    logic          is_pass;
    logic          is_fail;
    logic          is_char;
    logic          wd_hit;
    logic          fifo_full;
    logic          fifo_empty;
    logic          char_pop;

    // A stalled pipeline repeats the same word; only a change to a nonzero value is an event.
    assign ev      = (tohost_csr != 32'd0) && (tohost_csr != prev);
    assign running = (state == ST_RUN);
    assign is_pass = ev && running && (tohost_csr == TOHOST_PASS);
    assign is_fail = ev && running && tohost_csr[0] && (tohost_csr != TOHOST_PASS);
    assign is_char = ev && running && !tohost_csr[0] && (tohost_csr[31:16] == CHAR_TAG);
    assign wd_hit  = (TIMEOUT_CYCLES != 32'd0) && (cycles == TIMEOUT_CYCLES);

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (is_pass)      state_nx = ST_PASS;
                else if (is_fail) state_nx = ST_FAIL;
                else if (wd_hit)  state_nx = ST_TIMEOUT;
            end
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            prev          <= '0;
            cycles        <= '0;
            fail_code     <= '0;
            char_overflow <= 1'b0;
        end else begin
            state <= state_nx;
            prev  <= tohost_csr;
            if (running && (cycles != 32'hFFFF_FFFF)) cycles <= cycles + 32'd1;
            if (is_fail) fail_code <= tohost_csr[31:1];
            if (is_char && fifo_full && !char_pop) char_overflow <= 1'b1;
        end
    end

    assign done      = (state != ST_RUN);
    assign pass      = (state == ST_PASS);
    assign fail      = (state == ST_FAIL);
    assign timeout   = (state == ST_TIMEOUT);
    assign state_dbg = state;

    // Drain handshake: char_data is the head whenever char_valid is high and is
    // consumed on any edge where char_valid && char_ready; it holds otherwise.
    assign char_valid = !fifo_empty;
    assign char_pop   = char_valid && char_ready;

    tohost_char_fifo #(
        .WIDTH (8),
        .DEPTH (CHAR_DEPTH)
    ) u_char_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (is_char),
        .push_data (tohost_csr[15:8]),
        .full      (fifo_full),
        .pop       (char_pop),
        .empty     (fifo_empty),
        .head      (char_data)
    );

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: directed runs, a queue-based reference model
// compared every cycle, and literal expectations for the planned scenarios.
module tb_tohost_monitor;
    import tohost_pkg::*;

    localparam logic [31:0] TO    = 32'd20;
    localparam int          DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   tohost_csr = '0;
    logic          char_ready = 1'b0;
    logic          done, pass, fail, timeout, char_valid, char_overflow;
    logic [30:0]   fail_code;
    logic [31:0]   cycles;
    logic [7:0]    char_data;
    tohost_state_t state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // reference model
    bit          m_pass, m_fail, m_timeout, m_ovf;
    logic [30:0] m_code;
    logic [31:0] m_cycles, m_prev;
    logic [7:0]  exp_q[$];

    logic [7:0] drain_exp [8] = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};

    // clock/reset
    always #5 clk = ~clk;

    tohost_monitor #(
        .TIMEOUT_CYCLES (TO),
        .CHAR_DEPTH     (DEPTH),
        .CHAR_TAG       (16'h0101)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tohost_csr    (tohost_csr),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .fail_code     (fail_code),
        .timeout       (timeout),
        .cycles        (cycles),
        .char_valid    (char_valid),
        .char_data     (char_data),
        .char_ready    (char_ready),
        .char_overflow (char_overflow),
        .state_dbg     (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock edge of the reference model, from the inputs sampled at that edge.
    task automatic model_step();
        bit run, ev, ended;
        if (rst) begin
            m_pass = 0; m_fail = 0; m_timeout = 0; m_ovf = 0;
            m_code = '0; m_cycles = '0; m_prev = '0;
            exp_q.delete();
        end else begin
            run   = !(m_pass || m_fail || m_timeout);
            ev    = (tohost_csr != 0) && (tohost_csr != m_prev);
            ended = 0;
            if (exp_q.size() > 0 && char_ready) void'(exp_q.pop_front());
            if (run && ev) begin
                if (tohost_csr == 32'd1) begin
                    m_pass = 1; ended = 1;
                end else if (tohost_csr[0]) begin
                    m_fail = 1; m_code = tohost_csr[31:1]; ended = 1;
                end else if (tohost_csr[31:16] == 16'h0101) begin
                    if (exp_q.size() < DEPTH) exp_q.push_back(tohost_csr[15:8]);
                    else m_ovf = 1;
                end
            end
            if (run && !ended && TO != 0 && m_cycles == TO) m_timeout = 1;
            if (run && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            m_prev = tohost_csr;
        end
    endtask

    // driver: inputs change 1 time unit after the edge that samples the previous set
    task automatic tick(input logic r, input logic [31:0] c, input logic rdy);
        rst = r; tohost_csr = c; char_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, rdy);
    endtask

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("done",      {31'd0, done},          {31'd0, m_pass | m_fail | m_timeout});
            check("pass",      {31'd0, pass},          {31'd0, m_pass});
            check("fail",      {31'd0, fail},          {31'd0, m_fail});
            check("timeout",   {31'd0, timeout},       {31'd0, m_timeout});
            check("fail_code", {1'b0, fail_code},      {1'b0, m_code});
            check("cycles",    cycles,                 m_cycles);
            check("overflow",  {31'd0, char_overflow}, {31'd0, m_ovf});
            check("char_valid", {31'd0, char_valid},   {31'd0, exp_q.size() > 0});
            check("char_data", {24'd0, char_data},     {24'd0, (exp_q.size() > 0) ? exp_q[0] : 8'h00});
            check("state", {30'd0, state_dbg},
                  {30'd0, m_pass ? ST_PASS : m_fail ? ST_FAIL : m_timeout ? ST_TIMEOUT : ST_RUN});
        end
    end

    initial begin
        // Pass after 5 idle cycles; counter freezes
        tick(1'b1, 32'd0, 1'b0);
        chk_en = 1'b1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cycles", cycles, 32'd0);
        check("rst_char_data", {24'd0, char_data}, 32'd0);
        idle(5, 1'b0);
        tick(1'b0, 32'h1, 1'b0);
        check("t1_pass", {31'd0, pass}, 32'd1);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_fail", {31'd0, fail}, 32'd0);
        check("t1_cycles", cycles, 32'd6);
        idle(4, 1'b0);
        check("t1_frozen", cycles, 32'd6);

        // Stalled fail word counts once; later pass and char are ignored
        tick(1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h7, 1'b0);
        check("t2_fail", {31'd0, fail}, 32'd1);
        check("t2_code", {1'b0, fail_code}, 32'd3);
        tick(1'b0, 32'd0, 1'b0);
        tick(1'b0, 32'h1, 1'b0);
        check("t2_nopass", {31'd0, pass}, 32'd0);
        tick(1'b0, 32'h0101_7800, 1'b0);
        check("t2_nochar", {31'd0, char_valid}, 32'd0);

        // 'H','i' with a consumer always ready; ignored even words
        tick(1'b1, 32'd0, 1'b1);
        tick(1'b0, 32'h0101_4800, 1'b1);
        check("t3_valid_h", {31'd0, char_valid}, 32'd1);
        check("t3_data_h", {24'd0, char_data}, 32'h48);
        tick(1'b0, 32'd0, 1'b1);
        check("t3_empty1", {31'd0, char_valid}, 32'd0);
        tick(1'b0, 32'h0101_6900, 1'b1);
        check("t3_data_i", {24'd0, char_data}, 32'h69);
        tick(1'b0, 32'd0, 1'b1);
        check("t3_empty2", {31'd0, char_valid}, 32'd0);
        tick(1'b0, 32'h0000_0010, 1'b1);
        tick(1'b0, 32'h0102_4100, 1'b1);
        check("t3_ignored", {31'd0, char_valid}, 32'd0);
        check("t3_running", {31'd0, done}, 32'd0);

        // Overflow at depth, then full with simultaneous push/pop
        tick(1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b0, 32'h0101_4100 + (32'(i) << 8), 1'b0);
        check("t4_overflow", {31'd0, char_overflow}, 32'd1);
        check("t4_head", {24'd0, char_data}, 32'h41);
        tick(1'b0, 32'h0101_5A00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("t4_drain", {24'd0, char_data}, {24'd0, drain_exp[i]});
            tick(1'b0, 32'd0, 1'b1);
        end
        check("t4_empty", {31'd0, char_valid}, 32'd0);

        // Watchdog fires at cycles==20; a pass on that cycle wins
        tick(1'b1, 32'd0, 1'b0);
        idle(20, 1'b0);
        check("t5_cycles20", cycles, 32'd20);
        check("t5_not_yet", {31'd0, timeout}, 32'd0);
        tick(1'b0, 32'd0, 1'b0);
        check("t5_timeout", {31'd0, timeout}, 32'd1);
        check("t5_done", {31'd0, done}, 32'd1);
        idle(3, 1'b0);
        tick(1'b1, 32'd0, 1'b0);
        idle(20, 1'b0);
        tick(1'b0, 32'h1, 1'b0);
        check("t5_pass", {31'd0, pass}, 32'd1);
        check("t5_no_timeout", {31'd0, timeout}, 32'd0);

        // Reset while failed with characters queued
        tick(1'b1, 32'd0, 1'b0);
        tick(1'b0, 32'h0101_6100, 1'b0);
        tick(1'b0, 32'h0101_6200, 1'b0);
        tick(1'b0, 32'h0101_6300, 1'b0);
        tick(1'b0, 32'h0000_0003, 1'b0);
        check("t6_fail", {31'd0, fail}, 32'd1);
        check("t6_queued", {31'd0, char_valid}, 32'd1);
        tick(1'b1, 32'd0, 1'b0);
        check("t6_done0", {31'd0, done}, 32'd0);
        check("t6_fail0", {31'd0, fail}, 32'd0);
        check("t6_code0", {1'b0, fail_code}, 32'd0);
        check("t6_cycles0", cycles, 32'd0);
        check("t6_valid0", {31'd0, char_valid}, 32'd0);
        check("t6_data0", {24'd0, char_data}, 32'd0);
        tick(1'b0, 32'h1, 1'b0);
        check("t6_pass", {31'd0, pass}, 32'd1);
        idle(2, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
